// File: rtl/alu_sequencer.sv
// Purpose: loads ALU operands A, B and the opcode from the switches in strict A->B->OP order, then latches the result.
// Latency: a load lands 2 edges after the button is first sampled high; the LEDs and o_done update 1 edge after the opcode load.
// Backpressure: none; a button pulse that the current state does not expect is dropped, and clear wins over every other button.
module alu_sequencer #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  input  logic               i_btn_clr,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_op,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic [NB_DATA-1:0] o_led_res,
  output logic               o_led_carry,
  output logic               o_done,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  // Bit order: {clr, op, b, a}
  logic [3:0] btn_raw;
  logic [3:0] btn_sync1;
  logic [3:0] btn_sync2;
  logic [3:0] btn_prev;
  logic [3:0] btn_pulse;

  logic pulse_a;
  logic pulse_b;
  logic pulse_op;
  logic pulse_clr;

  state_t             state;
  state_t             state_nxt;
  logic [NB_DATA-1:0] dato_a_nxt;
  logic [NB_DATA-1:0] dato_b_nxt;
  logic [NB_OP-1:0]   op_nxt;
  logic [NB_DATA-1:0] led_res_nxt;
  logic               led_carry_nxt;
  logic               done_nxt;

  assign btn_raw   = {i_btn_clr, i_btn_op, i_btn_b, i_btn_a};
  assign btn_pulse = btn_sync2 & ~btn_prev;
  assign pulse_a   = btn_pulse[0];
  assign pulse_b   = btn_pulse[1];
  assign pulse_op  = btn_pulse[2];
  assign pulse_clr = btn_pulse[3];

  // Two-flop synchronizer plus a previous-value flop per button, so that a held button makes a single rising-edge pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_sync1 <= '0;
      btn_sync2 <= '0;
      btn_prev  <= '0;
    end else begin
      btn_sync1 <= btn_raw;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
    end
  end

  // State and every output register update together; reset discards any sequence in progress
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_WAIT_A;
      o_dato_a    <= '0;
      o_dato_b    <= '0;
      o_op        <= '0;
      o_led_res   <= '0;
      o_led_carry <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_dato_a    <= dato_a_nxt;
      o_dato_b    <= dato_b_nxt;
      o_op        <= op_nxt;
      o_led_res   <= led_res_nxt;
      o_led_carry <= led_carry_nxt;
      o_done      <= done_nxt;
    end
  end

  // Next-state logic: clear wins; otherwise only the pulse the current state expects has any effect
  always_comb begin
    state_nxt     = state;
    dato_a_nxt    = o_dato_a;
    dato_b_nxt    = o_dato_b;
    op_nxt        = o_op;
    led_res_nxt   = o_led_res;
    led_carry_nxt = o_led_carry;
    done_nxt      = 1'b0;

    if (pulse_clr) begin
      state_nxt  = S_WAIT_A;
      dato_a_nxt = '0;
      dato_b_nxt = '0;
      op_nxt     = '0;
    end else begin
      case (state)
        S_WAIT_A: begin
          if (pulse_a) begin
            dato_a_nxt = i_sw;
            state_nxt  = S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (pulse_b) begin
            dato_b_nxt = i_sw;
            state_nxt  = S_WAIT_OP;
          end
        end
        S_WAIT_OP: begin
          if (pulse_op) begin
            op_nxt    = i_sw[NB_OP-1:0];
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          // The ALU inputs come straight from the operand registers, so they have been stable for this whole cycle
          led_res_nxt   = i_alu_res;
          led_carry_nxt = i_alu_carry;
          done_nxt      = 1'b1;
          state_nxt     = S_SHOW;
        end
        S_SHOW: begin
          if (pulse_a) begin
            dato_a_nxt = i_sw;
            state_nxt  = S_WAIT_B;
          end
        end
        default: begin
          state_nxt = S_WAIT_A;
        end
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: self-checking bench for alu_sequencer, with a small ALU model driving the DUT's ALU inputs.
// Latency: checks the 2-edge load latency and the 1-edge execute latency; an expected result is queued for each opcode load.
// Backpressure: none; an o_done pulse that arrives with no queued result counts as an error.
module tb_alu_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_a;
  logic       btn_b;
  logic       btn_op;
  logic       btn_clr;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [5:0] op;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic [7:0] led_res;
  logic       led_carry;
  logic       done;
  logic [2:0] state;

  typedef struct packed {
    logic       carry;
    logic [7:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   done_cnt;

  alu_sequencer #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sw       (sw),
    .i_btn_a    (btn_a),
    .i_btn_b    (btn_b),
    .i_btn_op   (btn_op),
    .i_btn_clr  (btn_clr),
    .o_dato_a   (dato_a),
    .o_dato_b   (dato_b),
    .o_op       (op),
    .i_alu_res  (alu_res),
    .i_alu_carry(alu_carry),
    .o_led_res  (led_res),
    .o_led_carry(led_carry),
    .o_done     (done),
    .o_state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: ADD, SUB, AND, OR, XOR, NOR; any other opcode gives 0
  function automatic exp_t alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o);
    exp_t        r;
    logic [8:0]  s;
    r = '0;
    case (o)
      6'h20: begin s = {1'b0, a} + {1'b0, b}; r.res = s[7:0]; r.carry = s[8]; end
      6'h22: r.res = a - b;
      6'h24: r.res = a & b;
      6'h25: r.res = a | b;
      6'h26: r.res = a ^ b;
      6'h27: r.res = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Drive the DUT's ALU inputs from the bench's own ALU model
  always_comb begin
    exp_t t;
    t         = alu_model(dato_a, dato_b, op);
    alu_res   = t.res;
    alu_carry = t.carry;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Each o_done pulse must match the oldest queued result
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("led_res", {24'd0, led_res}, {24'd0, e.res});
        chk("led_carry", {31'd0, led_carry}, {31'd0, e.carry});
      end
    end
  end

  // Press button `which` (0=A, 1=B, 2=OP, 3=CLR) for 4 cycles, then release it for 4 cycles
  task automatic press(input int which, input logic [7:0] v);
    @(negedge clk);
    sw = v;
    case (which)
      0: btn_a   = 1'b1;
      1: btn_b   = 1'b1;
      2: btn_op  = 1'b1;
      default: btn_clr = 1'b1;
    endcase
    repeat (4) @(negedge clk);
    btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0; btn_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o);
    press(0, a);
    press(1, b);
    sb.push_back(alu_model(a, b, o));
    press(2, {2'b00, o});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    checks = 0; errors = 0; done_cnt = 0;
    rst_n = 1'b0; sw = '0; btn_a = 0; btn_b = 0; btn_op = 0; btn_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_outs", {8'd0, dato_a, dato_b, led_res}, 32'd0);
    chk("rst_op_done", {24'd0, op, led_carry, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: 5 + 3, with exact load and execute latency
    press(0, 8'h05);
    chk("t1_a", {24'd0, dato_a}, 32'h05);
    chk("t1_st_b", {29'd0, state}, 32'd1);
    press(1, 8'h03);
    chk("t1_b", {24'd0, dato_b}, 32'h03);
    d0 = done_cnt;
    sb.push_back(alu_model(8'h05, 8'h03, 6'h20));
    @(negedge clk);
    sw = 8'h20; btn_op = 1'b1;
    @(posedge clk);          // E: first edge that samples the button high
    @(posedge clk); #1;      // E+1
    chk("t1_st_e1", {29'd0, state}, 32'd2);
    @(posedge clk); #1;      // E+2: opcode loads
    chk("t1_st_exec", {29'd0, state}, 32'd3);
    chk("t1_op", {26'd0, op}, 32'h20);
    chk("t1_nodone_exec", {31'd0, done}, 32'd0);
    @(posedge clk); #1;      // E+3: LEDs and o_done update
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_led", {24'd0, led_res}, 32'h08);
    chk("t1_st_show", {29'd0, state}, 32'd4);
    @(negedge clk);
    btn_op = 1'b0;
    repeat (6) @(negedge clk);
    chk("t1_one_done", done_cnt - d0, 32'd1);
    chk("t1_st_hold", {29'd0, state}, 32'd4);

    // Test 2: ADD with carry out, then AND
    run_op(8'hFF, 8'h01, 6'h20);
    chk("t2_add_res", {23'd0, led_carry, led_res}, {23'd0, 1'b1, 8'h00});
    run_op(8'h0F, 8'h3C, 6'h24);
    chk("t2_and_res", {23'd0, led_carry, led_res}, {23'd0, 1'b0, 8'h0C});

    // Test 3: presses out of order are ignored
    press(3, 8'h00);
    chk("t3_clr_st", {29'd0, state}, 32'd0);
    chk("t3_led_keep", {24'd0, led_res}, 32'h0C);
    press(1, 8'hAA);
    chk("t3_b_ign", {24'd0, dato_b}, 32'h00);
    chk("t3_st0", {29'd0, state}, 32'd0);
    press(0, 8'h11);
    press(2, 8'h24);
    chk("t3_op_ign", {26'd0, op}, 32'h00);
    chk("t3_st1", {29'd0, state}, 32'd1);
    press(3, 8'h00);

    // Test 4: hold A for 100 cycles and change the switches after edge E+2
    @(negedge clk);
    sw = 8'h5A; btn_a = 1'b1;
    repeat (3) @(posedge clk);
    #1 sw = 8'hC3;
    repeat (100) @(negedge clk);
    chk("t4_a_val", {24'd0, dato_a}, 32'h5A);
    chk("t4_st", {29'd0, state}, 32'd1);
    btn_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_st_after", {29'd0, state}, 32'd1);

    // Test 5: clear and opcode in the same cycle; clear wins
    press(1, 8'h22);
    chk("t5_st2", {29'd0, state}, 32'd2);
    d0 = done_cnt;
    @(negedge clk);
    sw = 8'h20; btn_clr = 1'b1; btn_op = 1'b1;
    repeat (4) @(negedge clk);
    btn_clr = 1'b0; btn_op = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_st", {29'd0, state}, 32'd0);
    chk("t5_ops", {8'd0, dato_a, dato_b, 2'b00, op}, 32'd0);
    chk("t5_led", {23'd0, led_carry, led_res}, 32'h00C);
    chk("t5_nodone", done_cnt - d0, 32'd0);

    // Test 6: reset asserted between clock edges during S_EXEC
    press(0, 8'h40);
    press(1, 8'h41);
    d0 = done_cnt;
    @(negedge clk);
    sw = 8'h20; btn_op = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("t6_in_exec", {29'd0, state}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_outs", {8'd0, dato_a, dato_b, led_res}, 32'd0);
    chk("t6_misc", {23'd0, op, led_carry, done, state}, 32'd0);
    btn_op = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_st", {29'd0, state}, 32'd0);
    chk("t6_nodone", done_cnt - d0, 32'd0);

    // An unknown opcode executes and latches 0
    run_op(8'h09, 8'h04, 6'h22);
    chk("t7_sub", {24'd0, led_res}, 32'h05);
    run_op(8'h09, 8'h04, 6'h3F);
    chk("t7_unk", {23'd0, led_carry, led_res}, 32'd0);
    chk("t7_unk_op", {26'd0, op}, 32'h3F);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
